fetch_seq: RTL

FETCH_SEQ -- requirements
Module: fetch_seq

---
 rtl/fetch_seq.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fetch_seq.sv
// Fetch sequencer: drives the PC register and instruction-memory request, applies
// exception/ERET/branch redirects and drains a stale in-flight fetch after a redirect.
// Optional performance counters are compiled in with `define FETCH_PERF_EN.
module fetch_seq (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PC,
  input  logic        Stall,
  input  logic        Br_Take,
  input  logic [31:0] Br_Target,
  input  logic        Exc_Req,
  input  logic        Eret_Req,
  input  logic [31:0] EPC,
  input  logic        IM_Ready,
  output logic [31:0] NPC,
  output logic        PC_En,
  output logic        IM_Req,
  output logic [31:0] IM_Addr,
  output logic        F_Valid,
  output logic        Flush_D
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] Fetch_Cnt,
  output logic [31:0] Bubble_Cnt
`endif
);

  localparam logic [31:0] TEXT_START = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  // pend_q: a FETCH request is already outstanding, so the address must stay on addr_q
  logic        pend_q, pend_d;

  logic        redirect;
  logic [31:0] target;

  // Exceptions and ERET come from M and override the F/D freeze; branches do not.
  always_comb begin
    redirect = Exc_Req | Eret_Req | (Br_Take & ~Stall);
    if (Exc_Req) begin
      target = EXC_VECTOR;
    end else if (Eret_Req) begin
      target = EPC;
    end else begin
      target = Br_Target;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pend_d  = pend_q;
    NPC     = PC;
    PC_En   = 1'b0;
    IM_Req  = 1'b0;
    IM_Addr = addr_q;
    F_Valid = 1'b0;
    Flush_D = 1'b0;

    case (state_q)
      BOOT: begin
        state_d = FETCH;
        pend_d  = 1'b0;
      end

      FETCH: begin
        IM_Req  = 1'b1;
        IM_Addr = pend_q ? addr_q : PC;
        addr_d  = IM_Addr;
        if (redirect) begin
          PC_En   = 1'b1;
          NPC     = target;
          Flush_D = 1'b1;
          pend_d  = 1'b0;
          state_d = IM_Ready ? FETCH : DRAIN;
        end else if (IM_Ready) begin
          // A stalled response is dropped; the same PC is requested again next cycle.
          pend_d = 1'b0;
          if (!Stall) begin
            F_Valid = 1'b1;
            PC_En   = 1'b1;
            NPC     = PC + 32'd4;
          end
        end else begin
          pend_d = 1'b1;
        end
      end

      DRAIN: begin
        IM_Req  = 1'b1;
        IM_Addr = addr_q;
        if (redirect) begin
          PC_En   = 1'b1;
          NPC     = target;
          Flush_D = 1'b1;
        end
        if (IM_Ready) begin
          state_d = FETCH;
          pend_d  = 1'b0;
        end
      end

      default: begin
        state_d = BOOT;
        pend_d  = 1'b0;
      end
    endcase

    // Reset overrides everything, including a response arriving this cycle.
    if (Reset) begin
      state_d = BOOT;
      addr_d  = TEXT_START;
      pend_d  = 1'b0;
      NPC     = PC;
      PC_En   = 1'b0;
      IM_Req  = 1'b0;
      F_Valid = 1'b0;
      Flush_D = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    state_q <= state_d;
    addr_q  <= addr_d;
    pend_q  <= pend_d;
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;
  logic        busy;

  assign busy = (state_q == FETCH) || (state_q == DRAIN);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else if (F_Valid) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end else if (busy) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign Fetch_Cnt  = fetch_cnt_q;
  assign Bubble_Cnt = bubble_cnt_q;
`else
  // Counters and their ports are not built.
`endif

endmodule
